// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point special-operand resolver.
package fp_pkg;

    localparam int unsigned FP_CLASS_W = 3;

    typedef enum logic [FP_CLASS_W-1:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_QNAN = 3'd4,
        FP_SNAN = 3'd5
    } fp_class_e;

    // Canonical quiet NaN {0, all-ones exponent, fraction MSB set}, right-aligned in 64 bits.
    function automatic logic [63:0] qnan_canon(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] q;
        q = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            q[man_w + i] = 1'b1;
        end
        q[man_w - 1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: word -> {ZERO,SUB,NORM,INF,QNAN,SNAN}.
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] word,
    output fp_class_e            cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             unused_sign;

    assign exp_f       = word[MAN_W +: EXP_W];
    assign man_f       = word[MAN_W-1:0];
    assign unused_sign = word[EXP_W+MAN_W];

    always_comb begin
        cls = FP_NORM;
        if (exp_f == '0) begin
            cls = (man_f == '0) ? FP_ZERO : FP_SUB;
        end else if (exp_f == '1) begin
            if (man_f == '0)
                cls = FP_INF;
            else if (man_f[MAN_W-1])
                cls = FP_QNAN;
            else
                cls = FP_SNAN;
        end
    end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage valid/ready special-operand resolver for the FP adder/subtractor.
// Build option: FPSP_STICKY_FLAGS_EN makes flag_inv sticky until flag_clr.
module fp_special_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic            in_sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic            out_special,
    output logic [FP_W-1:0] out_a,
    output logic [FP_W-1:0] out_b,
    output logic            flag_inv,
    input  logic            flag_clr
);

    localparam logic [FP_W-1:0] QNAN = FP_W'(qnan_canon(EXP_W, MAN_W));

    logic            s1_v;
    logic [FP_W-1:0] s1_a, s1_b;
    fp_class_e       s1_ca, s1_cb;
    logic [FP_W-1:0] b_adj;
    fp_class_e       ca, cb;
    logic            s2_en;
    logic            inv_r;

    assign b_adj = in_b ^ {in_sub, {(FP_W-1){1'b0}}};

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.word(in_a),  .cls(ca));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.word(b_adj), .cls(cb));

    assign s2_en    = !out_valid || out_ready;
    assign in_ready = !s1_v || !out_valid || out_ready;

    logic            res_special, res_inv;
    logic [FP_W-1:0] res;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sa, sb;

    always_comb begin
        a_nan  = (s1_ca == FP_QNAN) || (s1_ca == FP_SNAN);
        b_nan  = (s1_cb == FP_QNAN) || (s1_cb == FP_SNAN);
        a_inf  = (s1_ca == FP_INF);
        b_inf  = (s1_cb == FP_INF);
        a_zero = (s1_ca == FP_ZERO);
        b_zero = (s1_cb == FP_ZERO);
        sa     = s1_a[FP_W-1];
        sb     = s1_b[FP_W-1];

        res         = '0;
        res_special = 1'b1;
        res_inv     = 1'b0;
        if (a_nan || b_nan) begin
            res     = QNAN;
            res_inv = (s1_ca == FP_SNAN) || (s1_cb == FP_SNAN);
        end else if (a_inf && b_inf) begin
            if (sa != sb) begin
                res     = QNAN;
                res_inv = 1'b1;
            end else begin
                res = s1_a;
            end
        end else if (a_inf) begin
            res = s1_a;
        end else if (b_inf) begin
            res = s1_b;
        end else if (a_zero && b_zero) begin
            res = {sa & sb, {(FP_W-1){1'b0}}};
        end else if (a_zero) begin
            res = s1_b;
        end else if (b_zero) begin
            res = s1_a;
        end else begin
            res_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_ca       <= FP_ZERO;
            s1_cb       <= FP_ZERO;
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_special <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            inv_r       <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_a  <= in_a;
                    s1_b  <= b_adj;
                    s1_ca <= ca;
                    s1_cb <= cb;
                end
            end
            // inv_r follows occupancy so the flag reads 0 whenever stage 2 is empty.
            if (s2_en) begin
                out_valid <= s1_v;
                inv_r     <= s1_v && res_inv;
                if (s1_v) begin
                    out_res     <= res;
                    out_special <= res_special;
                    out_a       <= s1_a;
                    out_b       <= s1_b;
                end
            end
        end
    end

`ifdef FPSP_STICKY_FLAGS_EN
    logic inv_sticky;

    always_ff @(posedge clk) begin
        if (!rst_n)
            inv_sticky <= 1'b0;
        else if (flag_clr)
            inv_sticky <= 1'b0;
        else if (out_valid && out_ready && inv_r)
            inv_sticky <= 1'b1;
    end

    assign flag_inv = inv_sticky;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign flag_inv        = inv_r;
`endif

endmodule

// File: tb/tb_fp_special_pipe.sv
// Randomized self-checking bench for fp_special_pipe against a rule-level reference model.
module tb_fp_special_pipe;

    localparam logic [31:0] QN32 = 32'h7FC0_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
    logic        in_ready, out_valid, out_special, flag_inv;
    logic [31:0] in_a = '0, in_b = '0, out_res, out_a, out_b;

    fp_special_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_special(out_special),
        .out_a(out_a), .out_b(out_b), .flag_inv(flag_inv), .flag_clr(flag_clr)
    );

    logic        d_in_valid = 1'b0, d_in_sub = 1'b0, d_out_ready = 1'b1;
    logic        d_in_ready, d_out_valid, d_out_special, d_flag_inv;
    logic [63:0] d_in_a = '0, d_in_b = '0, d_out_res, d_out_a, d_out_b;

    fp_special_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_b(d_in_b), .in_sub(d_in_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_res(d_out_res), .out_special(d_out_special),
        .out_a(d_out_a), .out_b(d_out_b), .flag_inv(d_flag_inv), .flag_clr(flag_clr)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: classify by field values, then apply the priority rules.
    localparam int C_ZERO = 0, C_SUB = 1, C_NORM = 2, C_INF = 3, C_QNAN = 4, C_SNAN = 5;

    typedef struct {
        logic [31:0] res, a, b;
        logic        sp, inv;
    } exp_t;

    function automatic int cls(input logic [31:0] x);
        int e, m;
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        if (e == 0) return (m == 0) ? C_ZERO : C_SUB;
        if (e == 255) begin
            if (m == 0) return C_INF;
            return (m >= (1 << 22)) ? C_QNAN : C_SNAN;
        end
        return C_NORM;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b_in, input logic sub);
        exp_t r;
        logic [31:0] b;
        int ca, cb;
        b  = sub ? {~b_in[31], b_in[30:0]} : b_in;
        ca = cls(a);
        cb = cls(b);
        r.a = a; r.b = b; r.sp = 1'b1; r.inv = 1'b0; r.res = '0;
        if (ca >= C_QNAN || cb >= C_QNAN) begin
            r.res = QN32;
            r.inv = (ca == C_SNAN) || (cb == C_SNAN);
        end else if (ca == C_INF && cb == C_INF) begin
            if (a[31] != b[31]) begin r.res = QN32; r.inv = 1'b1; end
            else r.res = a;
        end else if (ca == C_INF) r.res = a;
        else if (cb == C_INF) r.res = b;
        else if (ca == C_ZERO && cb == C_ZERO) r.res = {a[31] & b[31], 31'b0};
        else if (ca == C_ZERO) r.res = b;
        else if (cb == C_ZERO) r.res = a;
        else r.sp = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case ($urandom_range(0, 6))
            0:       return {s, 31'b0};
            1:       return {s, 8'h00, (m == 0) ? 23'h1 : m};
            2, 3:    return {s, 8'($urandom_range(1, 254)), m};
            4:       return {s, 8'hFF, 23'b0};
            5:       return {s, 8'hFF, 1'b1, m[21:0]};
            default: return {s, 8'hFF, 1'b0, (m[21:0] == 0) ? 22'h1 : m[21:0]};
        endcase
    endfunction

    exp_t        q[$];
    int          occ = 0;
    logic        holding = 1'b0;
    logic [31:0] h_res, h_a, h_b;
    logic        h_sp;
    logic        sticky = 1'b0;

    // One clock: drive, sample at negedge, account for the handshakes, advance.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic rdy);
        exp_t e;
        logic del;
        in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = rdy;
        @(negedge clk);
        check("in_ready", in_ready, (occ < 2) || rdy);
        if (out_valid && holding) begin
            check("hold_res", out_res, h_res);
            check("hold_sp", out_special, h_sp);
            check("hold_a", out_a, h_a);
            check("hold_b", out_b, h_b);
        end
        del = out_valid && rdy;
        e.inv = 1'b0;
        if (out_valid && q.size() == 0) check("spurious_valid", out_valid, 1'b0);
        else if (del) begin
            e = q.pop_front();
            check("res", out_res, e.res);
            check("special", out_special, e.sp);
            check("out_a", out_a, e.a);
            check("out_b", out_b, e.b);
`ifndef FPSP_STICKY_FLAGS_EN
            check("inv", flag_inv, e.inv);
`endif
            occ--;
        end
`ifdef FPSP_STICKY_FLAGS_EN
        check("inv_sticky", flag_inv, sticky);
        if (flag_clr) sticky = 1'b0;
        else if (del && e.inv) sticky = 1'b1;
`else
        if (!out_valid) check("inv_idle", flag_inv, 1'b0);
`endif
        holding = out_valid && !rdy;
        h_res = out_res; h_a = out_a; h_b = out_b; h_sp = out_special;
        if (v && in_ready) begin
            q.push_back(model(a, b, s));
            occ++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_special", out_special, 1'b0);
        check("rst_flag_inv", flag_inv, 1'b0);
        check("rst_out_res", out_res, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Latency: accepted at edge 1, visible after edge 2.
        cycle(1'b1, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b1);
        check("lat1", out_valid, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("lat2", out_valid, 1'b1);

        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        cycle(1'b1, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1);
        cycle(1'b1, 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1);

        // Back-to-back stream with a three-cycle downstream stall.
        for (int i = 0; i < 12; i++)
            cycle(i < 8, rand_op(), rand_op(), 1'($urandom), !(i >= 3 && i <= 5));

        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom),
                  ($urandom_range(0, 3) != 0));

        for (int i = 0; i < 6; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("drained", q.size(), 0);

        // Wide format: Inf + (-Inf) through the binary64 instance.
        d_in_a = 64'h7FF0_0000_0000_0000;
        d_in_b = 64'hFFF0_0000_0000_0000;
        d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(posedge clk); #1;
        check("d64_valid", d_out_valid, 1'b1);
        check("d64_res", d_out_res, 64'h7FF8_0000_0000_0000);
        check("d64_special", d_out_special, 1'b1);
        check("d64_inv", d_flag_inv, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("d64_valid_after", d_out_valid, 1'b0);
`ifdef FPSP_STICKY_FLAGS_EN
        check("d64_inv_held", d_flag_inv, 1'b1);
`else
        check("d64_inv_idle", d_flag_inv, 1'b0);
`endif
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        sticky = 1'b0;
        check("d64_inv_clr", d_flag_inv, 1'b0);

        // Reset with both stages loaded and output stalled.
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        occ = 0;
        holding = 1'b0;
        sticky = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_flag_inv", flag_inv, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
